// File: rtl/apb3_cmd_requester_if.sv
// Bundle of the command stream, response stream and APB3 bus wires seen by the
// requester. The master modport is the requester view; slave is the far side.
interface apb3_cmd_requester_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [AddrWidth-1:0] cmd_addr;
  logic                 cmd_write;
  logic [DataWidth-1:0] cmd_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;

  logic [AddrWidth-1:0] paddr;
  logic [DataWidth-1:0] pwdata;
  logic                 pwrite;
  logic                 psel;
  logic                 penable;
  logic [DataWidth-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/apb3_cmd_requester.sv
// APB3 initiator: converts one valid/ready command into a single APB3 transfer
// and returns the outcome (data, slave error or timeout) on a response stream.
module apb3_cmd_requester #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input logic                  clk,
  input logic                  rst,
  apb3_cmd_requester_if.master bus
);

  localparam int CntWidth   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int CntLastInt = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(CntLastInt);
  localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CntWidth-1:0]  cnt;
  logic [AddrWidth-1:0] paddr_q;
  logic [DataWidth-1:0] pwdata_q;
  logic                 pwrite_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;
  logic                 timeout_q;
  logic                 idle_c;
  logic                 psel_c;
  logic                 penable_c;
  logic                 rsp_valid_c;
  logic                 timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    idle_c      = 1'b0;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    rsp_valid_c = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        idle_c = 1'b1;
        if (bus.cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        psel_c     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        if (bus.pready) begin
          state_next = RESP;
        end else if (TimeoutEn && (cnt == CntLast)) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data are captured only on acceptance so they stay put through SETUP
  // and ACCESS and keep their last value between transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
            pwrite_q <= bus.cmd_write;
          end
        end
        SETUP: cnt <= '0;
        ACCESS: begin
          if (bus.pready) begin
            err_q     <= bus.pslverr;
            rdata_q   <= pwrite_q ? '0 : bus.prdata;
            timeout_q <= 1'b0;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= '0;
          end else if (cnt != CntMax) begin
            cnt <= cnt + CntWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = idle_c & ~rst;
  assign bus.psel        = psel_c;
  assign bus.penable     = penable_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = timeout_q;

endmodule

// File: doc/apb3_cmd_requester.md
Name: apb3_cmd_requester

Overview:
- APB3 initiator that turns a simple valid/ready command stream into single APB3 transfers.
- Returns each result on a valid/ready response stream.
- It is the requester-side counterpart to APB3 responders such as apb_uart.
- Used by on-chip controllers and RTL-only benches to drive peripheral config buses without an external co-simulation requester.

Parameters:
- AddrWidth, 32, width of cmd_addr/paddr.
- DataWidth, 32, width of write/read data.
- TimeoutCycles, 256, max ACCESS-phase cycles waiting for pready before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_addr  in  AddrWidth  target address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  DataWidth  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
- rsp_rdata  out  DataWidth  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  AddrWidth  APB address.
- pwdata  out  DataWidth  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DataWidth  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - cmd_ready=1 from the first cycle after reset deasserts; cmd_ready=0 while rst=1.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid, latch addr/write/wdata into paddr/pwrite/pwdata; go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0.
  - Clear the timeout counter; go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - If pready=1: sample pslverr into rsp_err; rsp_rdata = pwrite ? 0 : prdata; rsp_timeout=0; go to RESP.
  - Else, if TimeoutCycles!=0 and the counter equals TimeoutCycles-1: rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
  - Else increment the counter.
  - Counter width is $clog2(TimeoutCycles+1), minimum 1, and it never wraps.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp fields stay stable until rsp_ready=1; then go to IDLE and drop rsp_valid.
- Latency:
  - Command accepted at cycle N → SETUP N+1 → ACCESS N+2.
  - With pready=1 at N+2, rsp_valid asserts at N+3.
  - Best-case throughput is one transfer per 4 cycles when rsp_ready is held high.
- APB rules:
  - paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS.
  - Outside a transfer they hold their last value.
  - penable is never 1 while psel=0.
  - pready, pslverr and prdata are ignored outside ACCESS.
- Boundary conditions:
  - Only one outstanding transfer; cmd_ready=0 in SETUP/ACCESS/RESP.
  - A cmd_valid held during RESP is accepted only after returning to IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
  - Timeout abort deasserts psel in the same cycle RESP is entered; a late pready is ignored.
  - Reset mid-transfer: next edge forces IDLE with psel=penable=rsp_valid=0; the pending response is lost.

Test Plan:
- Write, zero-wait responder: cmd addr=0x10, wdata=0xA5, write=1 → psel rises N+1, penable N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states, prdata=0xDEADBEEF → penable held 4 cycles with paddr stable; rsp_rdata=0xDEADBEEF, rsp_valid 1 cycle after pready.
- Read, responder returns pslverr=1 with pready → rsp_err=1, rsp_timeout=0.
- TimeoutCycles=8, responder never asserts pready → psel drops after exactly 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; a later pready is ignored.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid held → rsp fields stable, cmd_ready=0 throughout; second command accepted the cycle after the response handshake.
- rst asserted during ACCESS → next cycle psel=penable=0, state IDLE, cmd_ready=1 after rst drops, no rsp_valid.
